// File: rtl/naneye_pixel_deser.sv
// NanEye pixel deserialiser: frames 12-bit serial words (start '1', 10 data bits MSB first,
// stop '0') from the Manchester sampler into pixels with column/row bookkeeping.
module naneye_pixel_deser #(
    parameter int PIX_PER_LINE    = 250,
    parameter int LINES_PER_FRAME = 250,
    parameter int WORD_BITS       = 12
) (
    input  logic       SCLOCK,
    input  logic       RESET,
    input  logic       S_DATA,
    input  logic       S_WREN,
    input  logic       frame_sync_start,
    output logic [9:0] PIX_DATA,
    output logic       PIX_VALID,
    output logic [7:0] PIX_COL,
    output logic [7:0] PIX_ROW,
    output logic       LINE_END,
    output logic       FRAME_END,
    output logic       WORD_ERR,
    output logic       FRAME_SHORT,
    output logic [7:0] ERR_CNT
);

    localparam int                CNT_W     = $clog2(WORD_BITS + 1);
    localparam int                DATA_BITS = 10;
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WORD_BITS - 1);
    localparam logic [7:0]        LAST_COL  = 8'(PIX_PER_LINE - 1);
    localparam logic [7:0]        LAST_ROW  = 8'(LINES_PER_FRAME - 1);

    typedef enum logic [1:0] {IDLE, HUNT, SHIFT, DONE} state_e;

    state_e                 state_q, state_d;
    // The final bit of a word is evaluated straight from S_DATA, so only the earlier bits are stored.
    logic [WORD_BITS-2:0]   sr_q, sr_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]             col_q, col_d;
    logic [7:0]             row_q, row_d;
    logic                   fss_prev_q;
    logic [DATA_BITS-1:0]   pix_data_q, pix_data_d;
    logic [7:0]             pix_col_q, pix_col_d;
    logic [7:0]             pix_row_q, pix_row_d;
    logic [7:0]             err_cnt_q, err_cnt_d;
    logic                   pix_valid_q, pix_valid_d;
    logic                   line_end_q, line_end_d;
    logic                   frame_end_q, frame_end_d;
    logic                   word_err_q, word_err_d;
    logic                   frame_short_q, frame_short_d;
    logic [WORD_BITS-1:0]   word_w;

    assign word_w = {sr_q, S_DATA};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d       = state_q;
        sr_d          = sr_q;
        bit_cnt_d     = bit_cnt_q;
        col_d         = col_q;
        row_d         = row_q;
        pix_data_d    = pix_data_q;
        pix_col_d     = pix_col_q;
        pix_row_d     = pix_row_q;
        err_cnt_d     = err_cnt_q;
        pix_valid_d   = 1'b0;
        line_end_d    = 1'b0;
        frame_end_d   = 1'b0;
        word_err_d    = 1'b0;
        frame_short_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (frame_sync_start && !fss_prev_q) begin
                    state_d   = HUNT;
                    col_d     = '0;
                    row_d     = '0;
                    err_cnt_d = '0;
                    sr_d      = '0;
                    bit_cnt_d = '0;
                end
            end
            HUNT, SHIFT: begin
                // Losing frame sync beats any word completing in the same cycle.
                if (!frame_sync_start) begin
                    state_d       = IDLE;
                    frame_short_d = 1'b1;
                    sr_d          = '0;
                    bit_cnt_d     = '0;
                end else if (S_WREN && state_q == HUNT) begin
                    if (S_DATA) begin
                        sr_d      = (WORD_BITS-1)'(1);
                        bit_cnt_d = CNT_W'(1);
                        state_d   = SHIFT;
                    end
                end else if (S_WREN) begin
                    sr_d      = word_w[WORD_BITS-2:0];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_CNT) begin
                        state_d   = HUNT;
                        sr_d      = '0;
                        bit_cnt_d = '0;
                        if (!word_w[0]) begin
                            pix_valid_d = 1'b1;
                            pix_data_d  = word_w[DATA_BITS:1];
                            pix_col_d   = col_q;
                            pix_row_d   = row_q;
                            if (col_q == LAST_COL) begin
                                col_d      = '0;
                                line_end_d = 1'b1;
                                if (row_q == LAST_ROW) begin
                                    row_d       = '0;
                                    frame_end_d = 1'b1;
                                    state_d     = DONE;
                                end else begin
                                    row_d = row_q + 8'd1;
                                end
                            end else begin
                                col_d = col_q + 8'd1;
                            end
                        end else begin
                            word_err_d = 1'b1;
                            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end
                end
            end
            DONE: begin
                if (!frame_sync_start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge SCLOCK) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (RESET) begin
            state_q       <= IDLE;
            sr_q          <= '0;
            bit_cnt_q     <= '0;
            col_q         <= '0;
            row_q         <= '0;
            fss_prev_q    <= 1'b1;  // a level already high after reset must not look like a new frame
            pix_data_q    <= '0;
            pix_col_q     <= '0;
            pix_row_q     <= '0;
            err_cnt_q     <= '0;
            pix_valid_q   <= 1'b0;
            line_end_q    <= 1'b0;
            frame_end_q   <= 1'b0;
            word_err_q    <= 1'b0;
            frame_short_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            bit_cnt_q     <= bit_cnt_d;
            col_q         <= col_d;
            row_q         <= row_d;
            fss_prev_q    <= frame_sync_start;
            pix_data_q    <= pix_data_d;
            pix_col_q     <= pix_col_d;
            pix_row_q     <= pix_row_d;
            err_cnt_q     <= err_cnt_d;
            pix_valid_q   <= pix_valid_d;
            line_end_q    <= line_end_d;
            frame_end_q   <= frame_end_d;
            word_err_q    <= word_err_d;
            frame_short_q <= frame_short_d;
        end
    end

    assign PIX_DATA    = pix_data_q;
    assign PIX_VALID   = pix_valid_q;
    assign PIX_COL     = pix_col_q;
    assign PIX_ROW     = pix_row_q;
    assign LINE_END    = line_end_q;
    assign FRAME_END   = frame_end_q;
    assign WORD_ERR    = word_err_q;
    assign FRAME_SHORT = frame_short_q;
    assign ERR_CNT     = err_cnt_q;

endmodule

// File: tb/tb_naneye_pixel_deser.sv
// Directed bench for naneye_pixel_deser on a 4x3 frame: word table plus hand-written
// abort, reset and saturation sequences.
module tb_naneye_pixel_deser;

    localparam int PPL = 4;
    localparam int LPF = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_data = 1'b0;
    logic       s_wren = 1'b0;
    logic       fss = 1'b0;
    logic [9:0] pix_data;
    logic       pix_valid;
    logic [7:0] pix_col;
    logic [7:0] pix_row;
    logic       line_end;
    logic       frame_end;
    logic       word_err;
    logic       frame_short;
    logic [7:0] err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    naneye_pixel_deser #(
        .PIX_PER_LINE   (PPL),
        .LINES_PER_FRAME(LPF),
        .WORD_BITS      (12)
    ) dut (
        .SCLOCK          (clk),
        .RESET           (rst),
        .S_DATA          (s_data),
        .S_WREN          (s_wren),
        .frame_sync_start(fss),
        .PIX_DATA        (pix_data),
        .PIX_VALID       (pix_valid),
        .PIX_COL         (pix_col),
        .PIX_ROW         (pix_row),
        .LINE_END        (line_end),
        .FRAME_END       (frame_end),
        .WORD_ERR        (word_err),
        .FRAME_SHORT     (frame_short),
        .ERR_CNT         (err_cnt)
    );

    typedef struct {
        logic [11:0] word;
        int          lead;   // zero strobes before the start bit
        int          gap;    // idle cycles between bits
        logic        valid;
        logic [9:0]  data;
        logic [7:0]  col;
        logic [7:0]  row;
        logic        le;
        logic        fe;
        logic        werr;
        logic [7:0]  ecnt;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic b);
        s_data = b;
        s_wren = 1'b1;
        tick();
        s_wren = 1'b0;
        s_data = 1'b0;
    endtask

    task automatic send_bits(input logic [11:0] w, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            strobe(w[11-i]);
            if (i < n - 1) repeat (gap) tick();
        end
    endtask

    task automatic check_pulses_low(input string tag);
        check({tag, " pulses"}, {27'd0, pix_valid, line_end, frame_end, word_err, frame_short}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{12'hD54, 0, 0, 1'b1, 10'h2AA, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{12'h803, 0, 0, 1'b0, 10'h2AA, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd1};
        vecs[2]  = '{12'hAAA, 2, 0, 1'b1, 10'h155, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[3]  = '{12'hFFE, 0, 2, 1'b1, 10'h3FF, 8'd1, 8'd0, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[4]  = '{12'h800, 0, 0, 1'b1, 10'h000, 8'd2, 8'd0, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[5]  = '{12'h802, 1, 1, 1'b1, 10'h001, 8'd3, 8'd0, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[6]  = '{12'hFFF, 0, 0, 1'b0, 10'h001, 8'd3, 8'd0, 1'b0, 1'b0, 1'b1, 8'd2};
        vecs[7]  = '{12'hC00, 0, 0, 1'b1, 10'h200, 8'd0, 8'd1, 1'b0, 1'b0, 1'b0, 8'd2};
        vecs[8]  = '{12'hA46, 0, 0, 1'b1, 10'h123, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0, 8'd2};
        vecs[9]  = '{12'h9E0, 0, 0, 1'b1, 10'h0F0, 8'd2, 8'd1, 1'b0, 1'b0, 1'b0, 8'd2};
        vecs[10] = '{12'h822, 0, 0, 1'b1, 10'h011, 8'd3, 8'd1, 1'b1, 1'b0, 1'b0, 8'd2};
        vecs[11] = '{12'h844, 0, 0, 1'b1, 10'h022, 8'd0, 8'd2, 1'b0, 1'b0, 1'b0, 8'd2};
        vecs[12] = '{12'h866, 0, 0, 1'b1, 10'h033, 8'd1, 8'd2, 1'b0, 1'b0, 1'b0, 8'd2};
        vecs[13] = '{12'hF86, 0, 0, 1'b1, 10'h3C3, 8'd2, 8'd2, 1'b0, 1'b0, 1'b0, 8'd2};
        vecs[14] = '{12'hD54, 0, 0, 1'b0, 10'h3C3, 8'd3, 8'd2, 1'b1, 1'b1, 1'b0, 8'd2};
        // Entry 13 is the last pixel; fix up its flags and entry 14 (in DONE) shows held values only.
        vecs[13].col = 8'd3; vecs[13].le = 1'b1; vecs[13].fe = 1'b1;
        vecs[12].col = 8'd2; vecs[11].col = 8'd1; vecs[10].col = 8'd0; vecs[10].row = 8'd2;
        vecs[10].le = 1'b0;  vecs[11].row = 8'd2; vecs[12].row = 8'd2;
        vecs[9].col = 8'd3;  vecs[9].le = 1'b1;   vecs[8].col = 8'd2; vecs[7].col = 8'd1;
        vecs[6].col = 8'd0;  vecs[6].row = 8'd1;  vecs[6].data = 10'h001;
        vecs[5].col = 8'd0;  vecs[5].row = 8'd1;  vecs[5].le = 1'b0;
        vecs[4].col = 8'd3;  vecs[4].le = 1'b1;   vecs[3].col = 8'd2; vecs[2].col = 8'd1;
        vecs[14].le = 1'b0;  vecs[14].fe = 1'b0;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        check("reset pix_data", {22'd0, pix_data}, 32'd0);
        check("reset col/row", {16'd0, pix_col, pix_row}, 32'd0);
        check("reset err_cnt", {24'd0, err_cnt}, 32'd0);
        check_pulses_low("reset");
        tick();

        // Strobes in IDLE are ignored
        send_bits(12'hD54, 12, 0);
        check("idle ignore valid", {31'd0, pix_valid}, 32'd0);

        fss = 1'b1;
        tick();

        for (int i = 0; i < 15; i++) begin
            repeat (vecs[i].lead) strobe(1'b0);
            send_bits(vecs[i].word, 12, vecs[i].gap);
            check($sformatf("v%0d valid", i), {31'd0, pix_valid}, {31'd0, vecs[i].valid});
            check($sformatf("v%0d data", i), {22'd0, pix_data}, {22'd0, vecs[i].data});
            check($sformatf("v%0d col", i), {24'd0, pix_col}, {24'd0, vecs[i].col});
            check($sformatf("v%0d row", i), {24'd0, pix_row}, {24'd0, vecs[i].row});
            check($sformatf("v%0d line_end", i), {31'd0, line_end}, {31'd0, vecs[i].le});
            check($sformatf("v%0d frame_end", i), {31'd0, frame_end}, {31'd0, vecs[i].fe});
            check($sformatf("v%0d word_err", i), {31'd0, word_err}, {31'd0, vecs[i].werr});
            check($sformatf("v%0d err_cnt", i), {24'd0, err_cnt}, {24'd0, vecs[i].ecnt});
            check($sformatf("v%0d frame_short", i), {31'd0, frame_short}, 32'd0);
            tick();
            check_pulses_low($sformatf("v%0d after", i));
        end

        // DONE -> IDLE on sync drop, no FRAME_SHORT; ERR_CNT held until next start
        fss = 1'b0;
        tick();
        check("done drop short", {31'd0, frame_short}, 32'd0);
        check("idle err_cnt held", {24'd0, err_cnt}, 32'd2);
        fss = 1'b1;
        tick();
        check("restart err_cnt clr", {24'd0, err_cnt}, 32'd0);

        // Abort after 5 bits
        send_bits(12'hFFF, 12, 0);
        check("abort pre werr", {31'd0, word_err}, 32'd1);
        send_bits(12'hD54, 5, 0);
        fss = 1'b0;
        tick();
        check("abort short", {31'd0, frame_short}, 32'd1);
        check("abort valid", {31'd0, pix_valid}, 32'd0);
        tick();
        check("abort short once", {31'd0, frame_short}, 32'd0);
        check("abort err_cnt held", {24'd0, err_cnt}, 32'd1);
        fss = 1'b1;
        tick();
        send_bits(12'hD54, 12, 0);
        check("abort next valid", {31'd0, pix_valid}, 32'd1);
        check("abort next col/row", {16'd0, pix_col, pix_row}, 32'd0);
        check("abort next err_cnt", {24'd0, err_cnt}, 32'd0);

        // Sync drops on the 12th strobe: abort wins
        send_bits(12'hAAA, 11, 0);
        fss = 1'b0;
        strobe(1'b0);
        check("race short", {31'd0, frame_short}, 32'd1);
        check("race valid", {31'd0, pix_valid}, 32'd0);
        check("race werr", {31'd0, word_err}, 32'd0);
        check("race data held", {22'd0, pix_data}, 32'h2AA);

        // Reset after 7 bits with sync held high
        fss = 1'b1;
        tick();
        send_bits(12'hD54, 12, 0);
        send_bits(12'hAAA, 12, 0);
        check("pre-reset col", {24'd0, pix_col}, 32'd1);
        send_bits(12'hFFE, 7, 0);
        rst = 1'b1;
        strobe(1'b1);
        rst = 1'b0;
        check_pulses_low("reset cycle");
        check("mid reset col/row", {16'd0, pix_col, pix_row}, 32'd0);
        check("mid reset data", {22'd0, pix_data}, 32'd0);
        tick();
        check_pulses_low("post reset");
        send_bits(12'hD54, 12, 0);
        check("held sync valid", {31'd0, pix_valid}, 32'd0);
        fss = 1'b0;
        tick();
        fss = 1'b1;
        tick();
        send_bits(12'h822, 12, 0);
        check("fresh frame valid", {31'd0, pix_valid}, 32'd1);
        check("fresh frame data", {22'd0, pix_data}, 32'h011);
        check("fresh frame col/row", {16'd0, pix_col, pix_row}, 32'd0);

        // ERR_CNT saturates at 255
        for (int i = 0; i < 256; i++) begin
            send_bits(12'h803, 12, 0);
            if (i == 254) check("err_cnt 255", {24'd0, err_cnt}, 32'd255);
        end
        check("err_cnt saturated", {24'd0, err_cnt}, 32'd255);
        check("sat werr", {31'd0, word_err}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
